tile_deck_shuffler: RTL
=======================

TILE_DECK_SHUFFLER -- requirements
Module: tile_deck_shuffler

Interface
REQ-001 SHALL have port CLOCK_50  input  1  sole clock, rising-edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  single-cycle request to build a new deck.
REQ-004 SHALL have port rd_idx_a  input  4  tile slot 0-9 to read on port A.
REQ-005 SHALL have port rd_idx_b  input  4  tile slot 0-9 to read on port B.
REQ-006 SHALL have port rd_code_a  output  11  tile code of slot rd_idx_a; combinational.
REQ-007 SHALL have port rd_code_b  output  11  tile code of slot rd_idx_b; combinational.
REQ-008 SHALL have port match  output  1  high when ready=1, rd_idx_a!=rd_idx_b, both indices <=9 and colour fields equal.
REQ-009 SHALL have port busy  output  1  high while the deck is being built.
REQ-010 SHALL have port ready  output  1  high while the deck is valid and stable.

Function
REQ-011 Tile code layout SHALL be [10:9] row=0, [8:7] col=0, [6:1] colour, [0] flipped=0.
REQ-012 A deck SHALL hold 10 slots; colours 1-5 SHALL each appear in exactly two slots.
REQ-013 A 16-bit Galois LFSR (mask 16'hB400, seed 16'hACE1) SHALL advance every cycle, including in IDLE; it SHALL never reach zero.
REQ-014 The FSM SHALL have four states: IDLE, FILL, SHUFFLE and READY.
REQ-015 In IDLE or READY, start=1 SHALL move the FSM to FILL on the next edge; ready SHALL drop in that same cycle.
REQ-016 FILL SHALL last 1 cycle: slot k gets colour (k>>1)+1, and index i is set to 9.
REQ-017 SHUFFLE SHALL last exactly 9 cycles, i=9 down to 1.
REQ-018 Each SHUFFLE cycle SHALL compute j = (lfsr[7:0]*(i+1))>>8 (range 0..i), swap slots i and j, then decrement i.
REQ-019 After i=1, the FSM SHALL enter READY; ready SHALL be 1 exactly 11 cycles after the edge that sampled start.
REQ-020 busy SHALL be 1 in FILL and SHUFFLE only; busy and ready SHALL never both be 1.
REQ-021 start SHALL be ignored in FILL and SHUFFLE.
REQ-022 Slot contents SHALL stay constant in READY.
REQ-023 rd_idx >9 SHALL return code 11'b0 and force match=0.
REQ-024 Read ports SHALL return slot contents in every state; contents are valid only when ready=1.

Reset
REQ-025 reset=1 SHALL immediately, and at any time including mid-SHUFFLE, apply the following:
- state=IDLE, i=0, LFSR=16'hACE1;
- all slots=0;
- busy=0, ready=0, match=0.
REQ-026 The first start after reset SHALL begin a full FILL/SHUFFLE sequence.

Configuration
REQ-027 With macro TILE_DECK_FIXED_EN defined, SHUFFLE SHALL be skipped.
REQ-028 In that mode, FILL SHALL load the fixed colour pattern 1,2,3,4,2,4,3,1,5,5 for slots 0-9, and ready SHALL assert 2 cycles after start.
REQ-029 Without the macro, REQ-016..REQ-019 SHALL apply.

Structure
REQ-030 Package tile_pkg SHALL hold:
- TILE_W=11 and NUM_TILES=10;
- colour field LSB/MSB;
- LFSR_SEED and LFSR_MASK;
- the FSM state enum;
- the fixed-deck colour table.
REQ-031 Sub-module deck_lfsr SHALL contain the LFSR, with ports CLOCK_50, reset and out[15:0].

Verification
REQ-032 Reset, then start at cycle 5 -> busy at cycles 6-15, ready=1 from cycle 16, each colour 1-5 present exactly twice.
REQ-033 In READY, drive rd_idx_a/b across all 45 distinct pairs -> match=1 on exactly 5 pairs; rd_idx_a=rd_idx_b=3 -> match=0; rd_idx_a=12 -> rd_code_a=0, match=0.
REQ-034 start pulses during SHUFFLE -> ignored; ready still arrives exactly 11 cycles after the first start.
REQ-035 reset asserted on the 4th SHUFFLE cycle -> the same cycle shows busy=0, ready=0 and slots=0; a later start gives a valid deck.
REQ-036 Two starts issued at different LFSR phases -> decks differ.
REQ-037 With TILE_DECK_FIXED_EN -> deck is 1,2,3,4,2,4,3,1,5,5 and ready 2 cycles after start.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared types and constants for the tile deck shuffler.
// TILE_DECK_FIXED_EN selects the fixed deck used for deterministic builds.
package tile_pkg;

    localparam int TILE_W    = 11;
    localparam int NUM_TILES = 10;
    localparam int IDX_W     = 4;
    localparam int COL_LSB   = 1;
    localparam int COL_MSB   = 6;
    localparam int COL_W     = COL_MSB - COL_LSB + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = 4'd9;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SHUFFLE,
        READY
    } state_t;

    localparam logic [COL_W-1:0] FIXED_DECK [NUM_TILES] = '{
        6'd1, 6'd2, 6'd3, 6'd4, 6'd2,
        6'd4, 6'd3, 6'd1, 6'd5, 6'd5
    };

    // Row, column and flipped fields are always zero in a fresh deck.
    function automatic logic [TILE_W-1:0] make_code(
        input logic [COL_W-1:0] colour
    );
        return {4'b0000, colour, 1'b0};
    endfunction

endpackage

// File: rtl/tile_deck_shuffler_lfsr.sv
// Free-running 16-bit Galois LFSR feeding the shuffle index.
// Runs every cycle so the deck depends on when start arrives.
module deck_lfsr
    import tile_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        reset,
    output logic [15:0] out
);

    // Shift right, folding the feedback mask in when a one drops out.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            out <= LFSR_SEED;
        end else begin
            out <= {1'b0, out[15:1]} ^ (out[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/tile_deck_shuffler.sv
// Builds a 10-slot memory-game deck of colour pairs and shuffles it.
// Define TILE_DECK_FIXED_EN to skip shuffling and load a fixed deck.
module tile_deck_shuffler
    import tile_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  rd_idx_a,
    input  logic [IDX_W-1:0]  rd_idx_b,
    output logic [TILE_W-1:0] rd_code_a,
    output logic [TILE_W-1:0] rd_code_b,
    output logic              match,
    output logic              busy,
    output logic              ready
);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  i_q;
    logic [IDX_W-1:0]  j;
    logic [15:0]       lfsr;
    logic [TILE_W-1:0] slots [NUM_TILES];

    deck_lfsr u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .out      (lfsr)
    );

    // Scale the low LFSR byte into 0..i for the Fisher-Yates swap partner.
    assign j = 4'(((lfsr & 16'h00FF) * {12'd0, i_q + 4'd1}) >> 8);

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and status; ready falls as soon as a rebuild is requested.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FILL;
            end
            FILL: begin
                busy = 1'b1;
`ifdef TILE_DECK_FIXED_EN
                state_d = READY;
`else
                state_d = SHUFFLE;
`endif
            end
            SHUFFLE: begin
                busy = 1'b1;
                if (i_q == 4'd1) state_d = READY;
            end
            READY: begin
                ready = !start;
                if (start) state_d = FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    // Deck storage: load pairs in FILL, swap one slot per SHUFFLE cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            i_q <= '0;
            for (int k = 0; k < NUM_TILES; k++) begin
                slots[k] <= '0;
            end
        end else if (state_q == FILL) begin
            i_q <= LAST_IDX;
            for (int k = 0; k < NUM_TILES; k++) begin
`ifdef TILE_DECK_FIXED_EN
                slots[k] <= make_code(FIXED_DECK[k]);
`else
                slots[k] <= make_code(6'((k >> 1) + 1));
`endif
            end
        end else if (state_q == SHUFFLE) begin
            slots[i_q] <= slots[j];
            slots[j]   <= slots[i_q];
            i_q        <= i_q - 4'd1;
        end
    end

    assign rd_code_a = (rd_idx_a <= LAST_IDX) ? slots[rd_idx_a] : '0;
    assign rd_code_b = (rd_idx_b <= LAST_IDX) ? slots[rd_idx_b] : '0;

    assign match = ready
                && (rd_idx_a != rd_idx_b)
                && (rd_idx_a <= LAST_IDX)
                && (rd_idx_b <= LAST_IDX)
                && (rd_code_a[COL_MSB:COL_LSB] == rd_code_b[COL_MSB:COL_LSB]);

endmodule
